// File: rtl/rf_rom_walker_pkg.sv
// Shared types and constants for the refresh-interval decision-tree walker:
// node word layout, FSM states, feature selector codes and leaf results.
package rf_walker_pkg;

  localparam int FEAT_W = 8;
  localparam int PC_W   = 6;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_LEAF    = 3'd0;
  localparam sel_t SEL_REQ     = 3'd1;
  localparam sel_t SEL_LOAD    = 3'd2;
  localparam sel_t SEL_LLC     = 3'd3;
  localparam sel_t SEL_RISK    = 3'd4;
  localparam sel_t SEL_RB_LOC  = 3'd5;
  localparam sel_t SEL_RB_CONF = 3'd6;
  localparam sel_t SEL_ZERO    = 3'd7;

  localparam logic [FEAT_W-1:0] T32 = 8'd32;
  localparam logic [FEAT_W-1:0] T48 = 8'd48;
  localparam logic [FEAT_W-1:0] T64 = 8'd64;

  typedef struct packed {
    sel_t              sel;
    logic [FEAT_W-1:0] thr;
    logic [PC_W-1:0]   if_true;
    logic [PC_W-1:0]   if_false;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic instr_t mk_node(input sel_t sel, input logic [FEAT_W-1:0] thr,
                                     input logic [PC_W-1:0] t, input logic [PC_W-1:0] f);
    instr_t n;
    n.sel      = sel;
    n.thr      = thr;
    n.if_true  = t;
    n.if_false = f;
    return n;
  endfunction

  // A leaf carries its result in the threshold field.
  function automatic instr_t mk_leaf(input logic [FEAT_W-1:0] result);
    return mk_node(SEL_LEAF, result, '0, '0);
  endfunction

endpackage

// File: rtl/rf_rom_walker_if.sv
// Request/result bundle between the feature counters, the walker and the
// refresh-rate controller.
interface rf_rom_walker_if;
  import rf_walker_pkg::*;

  logic              start;
  logic [FEAT_W-1:0] req_per_cycle;
  logic [FEAT_W-1:0] conflict_load;
  logic [FEAT_W-1:0] llc_miss;
  logic [FEAT_W-1:0] traffic_risk;
  logic [FEAT_W-1:0] rb_locality;
  logic [FEAT_W-1:0] rb_conflict;
  logic [FEAT_W-1:0] t_refi;
  logic              done;

  modport master (
    output start, req_per_cycle, conflict_load, llc_miss,
           traffic_risk, rb_locality, rb_conflict,
    input  t_refi, done
  );

  modport slave (
    input  start, req_per_cycle, conflict_load, llc_miss,
           traffic_risk, rb_locality, rb_conflict,
    output t_refi, done
  );

endinterface

// File: rtl/rf_rom_walker_rom.sv
// Fixed 64-entry decision-tree node table, looked up combinationally by pc.
module rf_tree_rom
  import rf_walker_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  output instr_t          instr
);

  always_comb begin
    instr = mk_leaf(T32);
    case (pc)
      6'd0:    instr = mk_node(SEL_LLC,     8'd41,  6'd1,  6'd25);
      6'd1:    instr = mk_node(SEL_REQ,     8'd1,   6'd2,  6'd7);
      6'd2:    instr = mk_node(SEL_RB_LOC,  8'd247, 6'd3,  6'd6);
      6'd3:    instr = mk_node(SEL_RISK,    8'd0,   6'd4,  6'd62);
      6'd4:    instr = mk_leaf(T48);
      6'd6:    instr = mk_leaf(T64);
      6'd7:    instr = mk_node(SEL_REQ,     8'd1,   6'd8,  6'd15);
      6'd8:    instr = mk_node(SEL_RB_LOC,  8'd237, 6'd9,  6'd12);
      6'd9:    instr = mk_node(SEL_RISK,    8'd0,   6'd10, 6'd11);
      6'd10:   instr = mk_leaf(T32);
      6'd11:   instr = mk_node(SEL_RB_LOC,  8'd128, 6'd63, 6'd63);
      6'd12:   instr = mk_node(SEL_REQ,     8'd1,   6'd62, 6'd63);
      6'd15:   instr = mk_node(SEL_RB_LOC,  8'd154, 6'd16, 6'd17);
      6'd16:   instr = mk_leaf(T32);
      6'd17:   instr = mk_node(SEL_REQ,     8'd6,   6'd18, 6'd19);
      6'd18:   instr = mk_node(SEL_RB_LOC,  8'd169, 6'd62, 6'd63);
      6'd19:   instr = mk_node(SEL_REQ,     8'd18,  6'd20, 6'd21);
      6'd20:   instr = mk_node(SEL_LLC,     8'd33,  6'd62, 6'd63);
      6'd25:   instr = mk_node(SEL_RB_CONF, 8'd4,   6'd26, 6'd29);
      6'd61:   instr = mk_leaf(T32);
      6'd62:   instr = mk_leaf(T48);
      6'd63:   instr = mk_leaf(T64);
      default: instr = mk_leaf(T32);
    endcase
  end

endmodule

// File: rtl/rf_rom_walker.sv
// Decision-tree walker: samples six features on start, walks the node ROM one
// node per clock and reports the predicted tREFI class with a done strobe.
module rf_rom_walker
  import rf_walker_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  rf_rom_walker_if.slave bus
);

  localparam int N_FEAT = 6;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [FEAT_W-1:0] t_refi_reg, t_refi_next;
  logic              done_reg, done_next;
  logic [FEAT_W-1:0] hold_reg [N_FEAT];
  logic [FEAT_W-1:0] feat_in  [N_FEAT];
  logic              sample;
  logic [FEAT_W-1:0] feature;
  instr_t            instr;

  // Index i holds the feature selected by sel = i+1.
  assign feat_in[0] = bus.req_per_cycle;
  assign feat_in[1] = bus.conflict_load;
  assign feat_in[2] = bus.llc_miss;
  assign feat_in[3] = bus.traffic_risk;
  assign feat_in[4] = bus.rb_locality;
  assign feat_in[5] = bus.rb_conflict;

  rf_tree_rom u_rom (
    .pc    (pc_reg),
    .instr (instr)
  );

  always_comb begin
    feature = '0;
    case (instr.sel)
      SEL_REQ:     feature = hold_reg[0];
      SEL_LOAD:    feature = hold_reg[1];
      SEL_LLC:     feature = hold_reg[2];
      SEL_RISK:    feature = hold_reg[3];
      SEL_RB_LOC:  feature = hold_reg[4];
      SEL_RB_CONF: feature = hold_reg[5];
      default:     feature = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    t_refi_next = t_refi_reg;
    done_next   = done_reg;
    sample      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        done_next = 1'b0;
        if (bus.start) begin
          sample     = 1'b1;
          pc_next    = '0;
          state_next = ST_WALK;
        end
      end
      ST_WALK: begin
        if (instr.sel == SEL_LEAF) begin
          t_refi_next = instr.thr;
          done_next   = 1'b1;
          state_next  = ST_DONE;
        end else begin
          pc_next = (feature <= instr.thr) ? instr.if_true : instr.if_false;
        end
      end
      ST_DONE: begin
        // done stays up as long as the requester keeps start high.
        if (!bus.start) begin
          done_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          done_next = 1'b1;
        end
      end
      default: begin
        done_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= '0;
      t_refi_reg <= '0;
      done_reg   <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) hold_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      t_refi_reg <= t_refi_next;
      done_reg   <= done_next;
      if (sample) begin
        for (int i = 0; i < N_FEAT; i++) hold_reg[i] <= feat_in[i];
      end
    end
  end

  assign bus.t_refi = t_refi_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_rf_rom_walker.sv
// Randomized bench for rf_rom_walker against a table-driven software walk of
// the node ROM, checking done/t_refi on every falling edge.
module tb_rf_rom_walker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_rom_walker_if bus ();

  rf_rom_walker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  logic       exp_done;
  logic [7:0] exp_trefi;
  int         txn_no = 0;

  int rom_sel [64];
  int rom_thr [64];
  int rom_t   [64];
  int rom_f   [64];

  task automatic set_node(input int a, input int s, input int th, input int t, input int f);
    rom_sel[a] = s; rom_thr[a] = th; rom_t[a] = t; rom_f[a] = f;
  endtask

  task automatic build_rom();
    for (int i = 0; i < 64; i++) set_node(i, 0, 32, 0, 0);
    set_node(0, 3, 41, 1, 25);   set_node(1, 1, 1, 2, 7);
    set_node(2, 5, 247, 3, 6);   set_node(3, 4, 0, 4, 62);
    set_node(4, 0, 48, 0, 0);    set_node(6, 0, 64, 0, 0);
    set_node(7, 1, 1, 8, 15);    set_node(8, 5, 237, 9, 12);
    set_node(9, 4, 0, 10, 11);   set_node(11, 5, 128, 63, 63);
    set_node(12, 1, 1, 62, 63);  set_node(15, 5, 154, 16, 17);
    set_node(17, 1, 6, 18, 19);  set_node(18, 5, 169, 62, 63);
    set_node(19, 1, 18, 20, 21); set_node(20, 3, 33, 62, 63);
    set_node(25, 6, 4, 26, 29);
    set_node(62, 0, 48, 0, 0);   set_node(63, 0, 64, 0, 0);
  endtask

  // feat[1..6] are the features by selector code; feat[0], feat[7] unused.
  function automatic void model_walk(input int feat[8], output int res, output int depth);
    int pc = 0;
    int f;
    depth = 0;
    for (int step = 0; step < 64 && rom_sel[pc] != 0; step++) begin
      f = (rom_sel[pc] == 7) ? 0 : feat[rom_sel[pc]];
      pc = (f <= rom_thr[pc]) ? rom_t[pc] : rom_f[pc];
      depth++;
    end
    res = rom_thr[pc];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (bus.done !== exp_done || bus.t_refi !== exp_trefi) begin
        n_bad++;
        $display("FAIL cycle_check @%0t: done=%0b t_refi=%0d, expected done=%0b t_refi=%0d",
                 $time, bus.done, bus.t_refi, exp_done, exp_trefi);
      end
    end
  end

  task automatic apply(input int feat[8]);
    bus.req_per_cycle = 8'(feat[1]);
    bus.conflict_load = 8'(feat[2]);
    bus.llc_miss      = 8'(feat[3]);
    bus.traffic_risk  = 8'(feat[4]);
    bus.rb_locality   = 8'(feat[5]);
    bus.rb_conflict   = 8'(feat[6]);
  endtask

  task automatic scramble();
    bus.req_per_cycle = 8'($urandom_range(0, 255));
    bus.conflict_load = 8'($urandom_range(0, 255));
    bus.llc_miss      = 8'($urandom_range(0, 255));
    bus.traffic_risk  = 8'($urandom_range(0, 255));
    bus.rb_locality   = 8'($urandom_range(0, 255));
    bus.rb_conflict   = 8'($urandom_range(0, 255));
  endtask

  // Values clustered around the tree thresholds so every branch gets exercised.
  function automatic int rnd_feature(input int s);
    int b = 0;
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 255);
    case (s)
      1: case ($urandom_range(0, 2)) 0: b = 1; 1: b = 6; default: b = 18; endcase
      2: b = 128;
      3: b = ($urandom_range(0, 1) == 0) ? 33 : 41;
      4: b = 0;
      5: case ($urandom_range(0, 4)) 0: b = 128; 1: b = 154; 2: b = 169; 3: b = 237; default: b = 247; endcase
      default: b = 4;
    endcase
    v = b - 1 + $urandom_range(0, 2);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  // Entered just after a rising edge with the DUT idle; returns just after the
  // edge at which done falls.
  task automatic run_txn(input int feat[8], input int hold, output int res);
    int d;
    int last;
    apply(feat);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    model_walk(feat, res, d);
    last = ((hold > d + 1) ? hold : d + 1) + 1;
    if (hold == 0) bus.start = 1'b0;
    scramble();
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      if (n == d + 1) begin
        exp_done  = 1'b1;
        exp_trefi = 8'(res);
      end
      if (n == last) begin
        exp_done = 1'b0;
      end else begin
        if (n >= hold) bus.start = 1'b0;
        scramble();
      end
    end
    txn_no++;
    $display("txn %0d: req=%0d load=%0d llc=%0d risk=%0d loc=%0d conf=%0d hold=%0d depth=%0d -> t_refi=%0d (model %0d)",
             txn_no, feat[1], feat[2], feat[3], feat[4], feat[5], feat[6], hold, d, bus.t_refi, res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fv[8];
    int r;
    int d;

    build_rom();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    scramble();
    exp_done  = 1'b0;
    exp_trefi = 8'd0;
    chk_en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", int'(bus.done), 0);
    check("reset_t_refi", int'(bus.t_refi), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rule 1: depth 4, result 48, start pulsed for one cycle.
    fv = '{0, 0, 0, 40, 0, 247, 0, 0};
    model_walk(fv, r, d);
    check("rule1_model_res", r, 48);
    check("rule1_model_depth", d, 4);
    run_txn(fv, 0, r);
    check("rule1_dut", int'(bus.t_refi), 48);

    // Rule 4: risk above zero diverts node 3 to leaf 62.
    fv = '{0, 0, 10, 40, 1, 247, 0, 0};
    model_walk(fv, r, d);
    check("rule4_model_res", r, 48);
    run_txn(fv, 1, r);
    check("rule4_dut", int'(bus.t_refi), 48);

    // High request rate: 0-1-7-15-16.
    fv = '{0, 17, 0, 41, 0, 146, 5, 0};
    model_walk(fv, r, d);
    check("highreq_model_res", r, 32);
    check("highreq_model_depth", d, 4);
    run_txn(fv, 0, r);
    check("highreq_dut", int'(bus.t_refi), 32);

    // Deepest path, with start held well past done.
    fv = '{0, 17, 0, 41, 0, 242, 5, 0};
    model_walk(fv, r, d);
    check("deep_model_res", r, 64);
    check("deep_model_depth", d, 7);
    run_txn(fv, 12, r);
    check("deep_dut", int'(bus.t_refi), 64);

    // Reset in the middle of a walk.
    fv = '{0, 0, 0, 40, 0, 247, 0, 0};
    apply(fv);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_done  = 1'b0;
    exp_trefi = 8'd0;
    @(negedge clk);
    check("midwalk_rst_done", int'(bus.done), 0);
    check("midwalk_rst_t_refi", int'(bus.t_refi), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // llc above 41 goes right at the root: 0-25-26.
    fv = '{0, 0, 0, 42, 0, 0, 4, 0};
    model_walk(fv, r, d);
    check("llc42_model_res", r, 32);
    check("llc42_model_depth", d, 2);
    run_txn(fv, 0, r);
    check("llc42_dut", int'(bus.t_refi), 32);

    for (int t = 0; t < 150; t++) begin
      for (int s = 1; s <= 6; s++) fv[s] = rnd_feature(s);
      fv[0] = 0;
      fv[7] = 0;
      run_txn(fv, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0, r);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
